fft_frame_sequencer: RTL and testbench

//   Streaming front/back end for the combinational FFT/iFFT core. Collects
//   one frame of 2*N words over a valid/ready input and holds it stable on
//   the core's x[] array together with the direction select. It then waits a

---
 rtl/fft_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Streaming wrapper around a combinational FFT/iFFT core: gathers a 2*N-word frame,
// holds it on the core inputs, waits for the core to settle, then streams X[] out.
module fft_frame_sequencer #(
  parameter int unsigned N      = 16,
  parameter int unsigned W      = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W:0]              in_data,
  input  logic                    in_last,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W+N-1:0]          out_data,
  output logic                    out_last,
  output logic [2*N-1:0][W:0]     core_x,
  output logic                    core_sel,
  input  logic [2*N-1:0][W+N-1:0] core_X,
  output logic                    busy,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned Words = 2 * N;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned CntW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSettle, StUnload} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]          rd_idx_q, rd_idx_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [Words-1:0][W:0]    core_x_q, core_x_d;
  logic                     sel_q, sel_d;
  logic [Words-1:0][W+N-1:0] res_q, res_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     err_q, err_d;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    cnt_d       = cnt_q;
    core_x_d    = core_x_q;
    sel_d       = sel_q;
    res_d       = res_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          core_x_d[0] = in_data;
          sel_d       = in_mode;
          wr_idx_d    = IdxW'(1);
          // A single-word frame ending here is malformed; drop it and stay idle.
          if (in_last) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          core_x_d[wr_idx_q] = in_data;
          if (wr_idx_q == LastIdx) begin
            // Full frame is kept even if in_last is missing; only flag it.
            err_d   = ~in_last;
            cnt_d   = CntW'(SETTLE);
            state_d = StSettle;
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            wr_idx_d = wr_idx_q + IdxW'(1);
          end
        end
      end

      StSettle: begin
        if (cnt_q == '0) begin
          res_d    = core_X;
          rd_idx_d = '0;
          state_d  = StUnload;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StUnload: begin
        out_valid = 1'b1;
        out_data  = res_q[rd_idx_q];
        out_last  = (rd_idx_q == LastIdx);
        if (out_ready) begin
          if (rd_idx_q == LastIdx) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + IdxW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      core_x_q    <= '0;
      sel_q       <= 1'b0;
      res_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cnt_q       <= cnt_d;
      core_x_q    <= core_x_d;
      sel_q       <= sel_d;
      res_q       <= res_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign core_x    = core_x_q;
  assign core_sel  = sel_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with N=4, W=8, SETTLE=2 and a simple
// combinational stand-in for the FFT core.
module tb_fft_frame_sequencer;

  localparam int unsigned N      = 4;
  localparam int unsigned W      = 8;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned WORDS  = 2 * N;

  typedef logic [W+N-1:0] oword_t;
  typedef oword_t oarr_t [WORDS];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b0;
  logic [W:0] in_data = '0;
  logic in_ready, out_valid, out_last, core_sel, busy, frame_err;
  logic [W+N-1:0] out_data;
  logic [WORDS-1:0][W:0] core_x;
  logic [WORDS-1:0][W+N-1:0] core_X;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [W:0] frame [WORDS];

  fft_frame_sequencer #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_x(core_x), .core_sel(core_sel), .core_X(core_X),
    .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Core stand-in: X[k] = sext(x[(k+1)%8]) + k (+100 for iFFT).
  function automatic oword_t core_fn(input logic [W:0] xv, input int k, input logic sel);
    return {{(N-1){xv[W]}}, xv} + oword_t'(k) + (sel ? oword_t'(100) : oword_t'(0));
  endfunction

  always_comb begin
    for (int k = 0; k < WORDS; k++) core_X[k] = core_fn(core_x[(k+1)%WORDS], k, core_sel);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [W:0] d, input logic l, input logic m);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_mode = m;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL put_word_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic sel, input logic last_ok);
    for (int i = 0; i < WORDS; i++)
      put_word(frame[i], (i == WORDS - 1) && last_ok, (i == 0) ? sel : ~sel);
  endtask

  task automatic collect(output oarr_t d, output logic [WORDS-1:0] l, output int n);
    int t = 0;
    n = 0; l = '0; out_ready = 1'b1;
    while (n < WORDS && t < 100) begin
      if (out_valid) begin d[n] = out_data; l[n] = out_last; n++; end
      tick(); t++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (frame_err !== 1'b0 || out_last !== 1'b0 || out_data !== '0)
      begin errors++; $display("FAIL reset_outputs: err=%0b last=%0b data=%h want 0,0,0", frame_err, out_last, out_data); end
    checks++; if (core_x !== '0 || core_sel !== 1'b0)
      begin errors++; $display("FAIL reset_core: x=%h sel=%0b want 0,0", core_x, core_sel); end
    rst_n = 1'b1;
    tick();
    exp_cnt = 16'd0;
  endtask

  task automatic test_fft_impulse();
    oword_t imp_exp [WORDS] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd8};
    frame = '{9'd1, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
    out_ready = 1'b1;
    send_frame(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL impulse_settle c=%0d: valid=%0b ready=%0b want 0,0", c, out_valid, in_ready); end
      tick();
    end
    for (int k = 0; k < WORDS; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== imp_exp[k] || out_last !== (k == WORDS - 1))
        begin errors++; $display("FAIL impulse_word%0d: valid=%0b data=%0d last=%0b want 1,%0d,%0b",
                                 k, out_valid, out_data, out_last, imp_exp[k], k == WORDS - 1); end
      tick();
    end
    out_ready = 1'b0;
    exp_cnt++;
    checks++; if (frame_cnt !== exp_cnt || busy !== 1'b0)
      begin errors++; $display("FAIL impulse_done: cnt=%0d busy=%0b want %0d,0", frame_cnt, busy, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int c = 0;
    oword_t hold_d;
    logic hold_l;
    frame = '{9'h1F3, 9'h050, 9'h100, 9'h0FF, 9'h001, 9'h1FF, 9'h07A, 9'h133};
    out_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      put_word(frame[i], i == WORDS - 1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    while (n < WORDS && c < 100) begin
      out_ready = (c % 2 == 0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %0b want 0", c, in_ready); end
      if (out_valid && out_ready) begin
        checks++; if (out_data !== core_fn(frame[(n+1)%WORDS], n, 1'b1) || out_last !== (n == WORDS - 1))
          begin errors++; $display("FAIL bp_word%0d: data=%h last=%0b want %h,%0b", n, out_data, out_last,
                                   core_fn(frame[(n+1)%WORDS], n, 1'b1), n == WORDS - 1); end
        n++;
        tick();
      end else if (out_valid) begin
        hold_d = out_data; hold_l = out_last;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l)
          begin errors++; $display("FAIL bp_hold: valid=%0b data=%h last=%0b want 1,%h,%0b",
                                   out_valid, out_data, out_last, hold_d, hold_l); end
      end else begin
        tick();
      end
      c++;
    end
    out_ready = 1'b0;
    exp_cnt++;
    checks++; if (n !== WORDS) begin errors++; $display("FAIL bp_count: got %0d words want %0d", n, WORDS); end
    checks++; if (frame_cnt !== exp_cnt || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_done: cnt=%0d ready=%0b want %0d,1", frame_cnt, in_ready, exp_cnt); end
  endtask

  task automatic test_early_last();
    oarr_t got;
    logic [WORDS-1:0] lst;
    int n;
    bit seen = 1'b0;
    out_ready = 1'b0;
    frame = '{9'd10, 9'd20, 9'd30, 9'd40, 9'd50, 9'd60, 9'd70, 9'd80};
    for (int i = 0; i < 4; i++) put_word(frame[i], i == 3, 1'b0);
    checks++; if (frame_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL early_err: err=%0b busy=%0b ready=%0b want 1,0,1", frame_err, busy, in_ready); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_pulse: err=%0b want 0", frame_err); end
    repeat (6) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL early_no_output: out_valid=1 seen want 0"); end
    frame = '{9'h1A5, 9'h022, 9'h0C3, 9'h1FE, 9'h080, 9'h011, 9'h17F, 9'h004};
    send_frame(1'b0, 1'b1);
    collect(got, lst, n);
    exp_cnt++;
    checks++; if (n !== WORDS) begin errors++; $display("FAIL early_next_count: got %0d want %0d", n, WORDS); end
    for (int k = 0; k < WORDS; k++) begin
      checks++; if (got[k] !== core_fn(frame[(k+1)%WORDS], k, 1'b0) || lst[k] !== (k == WORDS - 1))
        begin errors++; $display("FAIL early_next_word%0d: data=%h last=%0b want %h,%0b", k, got[k], lst[k],
                                 core_fn(frame[(k+1)%WORDS], k, 1'b0), k == WORDS - 1); end
    end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL early_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_mode_latch();
    oarr_t got;
    logic [WORDS-1:0] lst;
    int n;
    frame = '{9'h0AA, 9'h155, 9'h003, 9'h1C0, 9'h040, 9'h0F0, 9'h10F, 9'h077};
    for (int i = 0; i < WORDS; i++) begin
      put_word(frame[i], i == WORDS - 1, (i == 0) ? 1'b1 : 1'(i % 2 == 0));
      checks++; if (core_sel !== 1'b1) begin errors++; $display("FAIL mode_sel word%0d: got %0b want 1", i, core_sel); end
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mode_err: got %0b want 0", frame_err); end
    collect(got, lst, n);
    exp_cnt++;
    checks++; if (n !== WORDS) begin errors++; $display("FAIL mode_count: got %0d want %0d", n, WORDS); end
    for (int k = 0; k < WORDS; k++) begin
      checks++; if (got[k] !== core_fn(frame[(k+1)%WORDS], k, 1'b1))
        begin errors++; $display("FAIL mode_word%0d: got %h want %h", k, got[k], core_fn(frame[(k+1)%WORDS], k, 1'b1)); end
    end
  endtask

  task automatic test_missing_last();
    oarr_t got;
    logic [WORDS-1:0] lst;
    int n;
    frame = '{9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'h1F0};
    send_frame(1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL nolast_err: err=%0b busy=%0b want 1,1", frame_err, busy); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nolast_pulse: err=%0b want 0", frame_err); end
    collect(got, lst, n);
    exp_cnt++;
    checks++; if (n !== WORDS || got[WORDS-1] !== core_fn(frame[0], WORDS - 1, 1'b0) || lst[WORDS-1] !== 1'b1)
      begin errors++; $display("FAIL nolast_data: n=%0d last_word=%h flag=%0b want %0d,%h,1", n, got[WORDS-1],
                               lst[WORDS-1], WORDS, core_fn(frame[0], WORDS - 1, 1'b0)); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL nolast_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_unload();
    int t = 0;
    bit seen = 1'b0;
    test_reset();
    frame = '{9'd11, 9'd22, 9'd33, 9'd44, 9'd55, 9'd66, 9'd77, 9'd88};
    send_frame(1'b0, 1'b1);
    out_ready = 1'b1;
    while (!out_valid && t < 20) begin tick(); t++; end
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1 || out_data !== core_fn(frame[4], 3, 1'b0))
      begin errors++; $display("FAIL rmu_pre: valid=%0b data=%h want 1,%h", out_valid, out_data, core_fn(frame[4], 3, 1'b0)); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== exp_cnt)
      begin errors++; $display("FAIL rmu_reset: valid=%0b busy=%0b ready=%0b cnt=%0d want 0,0,1,%0d",
                               out_valid, busy, in_ready, frame_cnt, exp_cnt); end
    rst_n = 1'b1;
    repeat (5) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL rmu_after: out_valid=1 seen want 0"); end
  endtask

  initial begin
    test_reset();
    test_fft_impulse();
    test_backpressure();
    test_early_last();
    test_mode_latch();
    test_missing_last();
    test_reset_mid_unload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
